// File: rtl/cache_way_controller_pkg.sv
// Shared types and constants for the cache way controller: FSM states,
// age width and the saturating age increment.
package cache_ctrl_pkg;

  localparam int AGE_W = 32;
  localparam logic [AGE_W-1:0] AGE_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    FILL   = 3'd2,
    UPDATE = 3'd3,
    FLUSH  = 3'd4
  } state_t;

  // Ages stick at the maximum rather than wrapping back to "most recent".
  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] age);
    return (age == AGE_MAX) ? age : age + 1'b1;
  endfunction

endpackage

// File: rtl/cache_way_controller_if.sv
// Access, fill and flush handshake bundle between tag compare / memory side
// (master) and the way controller (slave).
interface cache_way_controller_if #(
  parameter int SET_BITS = 4,
  parameter int N_POW    = 4
);

  logic                acc_valid;
  logic                acc_ready;
  logic [SET_BITS-1:0] acc_set;
  logic                acc_hit;
  logic [N_POW-1:0]    acc_way;
  logic                fill_req;
  logic [SET_BITS-1:0] fill_set;
  logic [N_POW-1:0]    fill_way;
  logic                fill_done;
  logic                done;
  logic [N_POW-1:0]    done_way;
  logic                flush_req;
  logic                flush_busy;

  modport master (
    output acc_valid, acc_set, acc_hit, acc_way, fill_done, flush_req,
    input  acc_ready, fill_req, fill_set, fill_way, done, done_way, flush_busy
  );

  modport slave (
    input  acc_valid, acc_set, acc_hit, acc_way, fill_done, flush_req,
    output acc_ready, fill_req, fill_set, fill_way, done, done_way, flush_busy
  );

endinterface

// File: rtl/cache_way_controller_replacement_scheme.sv
// Victim selection for one set: lowest-index empty way, otherwise the way
// with the strictly greatest age (ties resolve to the lowest index).
module replacement_scheme
  import cache_ctrl_pkg::*;
#(
  parameter int N_WAYS = 2,
  parameter int N_POW  = 4
) (
  input  logic [N_WAYS-1:0]            line_empty,
  input  logic [N_WAYS-1:0][AGE_W-1:0] line_age,
  output logic [N_POW-1:0]             victim_way
);

  logic             found;
  logic [AGE_W-1:0] best_age;

  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    best_age   = line_age[0];
    for (int w = 0; w < N_WAYS; w++) begin
      if (!found && line_empty[w]) begin
        victim_way = N_POW'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 1; w < N_WAYS; w++) begin
        if (line_age[w] > best_age) begin
          best_age   = line_age[w];
          victim_way = N_POW'(w);
        end
      end
    end
  end

endmodule

// File: rtl/cache_way_controller.sv
// Per-set valid/age owner and miss sequencer: ages lines on hits, picks and
// fills a victim on misses, and walks every set to flush.
module cache_way_controller
  import cache_ctrl_pkg::*;
#(
  parameter int N_WAYS   = 2,
  parameter int N_POW    = 4,
  parameter int N_SETS   = 16,
  parameter int SET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_way_controller_if.slave bus
);

  logic [N_SETS-1:0][N_WAYS-1:0]            valid_q, valid_d;
  logic [N_SETS-1:0][N_WAYS-1:0][AGE_W-1:0] age_q, age_d;
  state_t                                   state_q, state_d;
  logic [SET_BITS-1:0]                      set_q, set_d;
  logic [SET_BITS-1:0]                      flush_cnt_q, flush_cnt_d;
  logic [N_POW-1:0]                         fill_way_q, fill_way_d;
  logic [N_POW-1:0]                         done_way_q, done_way_d;
  logic                                     done_q, done_d;

  logic                                     accept;
  logic [N_POW-1:0]                         victim;
  logic [N_WAYS-1:0]                        sel_empty;
  logic [N_WAYS-1:0][AGE_W-1:0]             sel_age;

  assign bus.acc_ready  = (state_q == IDLE) && !bus.flush_req && !rst;
  assign bus.fill_req   = (state_q == FILL);
  assign bus.fill_set   = set_q;
  assign bus.fill_way   = fill_way_q;
  assign bus.done       = done_q;
  assign bus.done_way   = done_way_q;
  assign bus.flush_busy = (state_q == FLUSH);

  assign accept    = bus.acc_valid && bus.acc_ready;
  assign sel_empty = ~valid_q[set_q];
  assign sel_age   = age_q[set_q];

  replacement_scheme #(
    .N_WAYS (N_WAYS),
    .N_POW  (N_POW)
  ) u_replacement (
    .line_empty (sel_empty),
    .line_age   (sel_age),
    .victim_way (victim)
  );

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    age_d       = age_q;
    set_d       = set_q;
    flush_cnt_d = flush_cnt_q;
    fill_way_d  = fill_way_q;
    done_way_d  = done_way_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end else if (accept && bus.acc_hit) begin
          // The hit way is made youngest even if it is not marked valid.
          for (int w = 0; w < N_WAYS; w++) begin
            if (N_POW'(w) == bus.acc_way)
              age_d[bus.acc_set][w] = '0;
            else if (valid_q[bus.acc_set][w])
              age_d[bus.acc_set][w] = sat_inc(age_q[bus.acc_set][w]);
          end
          done_d     = 1'b1;
          done_way_d = bus.acc_way;
        end else if (accept) begin
          set_d   = bus.acc_set;
          state_d = SELECT;
        end
      end

      SELECT: begin
        fill_way_d = victim;
        state_d    = FILL;
      end

      FILL: begin
        if (bus.fill_done)
          state_d = UPDATE;
      end

      UPDATE: begin
        for (int w = 0; w < N_WAYS; w++) begin
          if (N_POW'(w) == fill_way_q) begin
            valid_d[set_q][w] = 1'b1;
            age_d[set_q][w]   = '0;
          end else if (valid_q[set_q][w]) begin
            age_d[set_q][w]   = sat_inc(age_q[set_q][w]);
          end
        end
        done_d     = 1'b1;
        done_way_d = fill_way_q;
        state_d    = IDLE;
      end

      FLUSH: begin
        valid_d[flush_cnt_q] = '0;
        age_d[flush_cnt_q]   = '0;
        flush_cnt_d          = flush_cnt_q + 1'b1;
        if (flush_cnt_q == SET_BITS'(N_SETS - 1))
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      age_q       <= '0;
      set_q       <= '0;
      flush_cnt_q <= '0;
      fill_way_q  <= '0;
      done_way_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      age_q       <= age_d;
      set_q       <= set_d;
      flush_cnt_q <= flush_cnt_d;
      fill_way_q  <= fill_way_d;
      done_way_q  <= done_way_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_cache_way_controller.sv
// Directed self-checking bench for cache_way_controller: misses, victim choice,
// hit aging and saturation, flush walk and reset during a fill.
module tb_cache_way_controller;

  localparam int N_WAYS   = 2;
  localparam int N_POW    = 4;
  localparam int N_SETS   = 16;
  localparam int SET_BITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   numChecks = 0;
  int   numFails  = 0;

  logic [N_SETS-1:0][N_WAYS-1:0][31:0] ageTmp;
  logic [3:0] flushSets [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd15};

  always #5 clk = ~clk;

  cache_way_controller_if #(.SET_BITS(SET_BITS), .N_POW(N_POW)) bus ();

  cache_way_controller #(
    .N_WAYS   (N_WAYS),
    .N_POW    (N_POW),
    .N_SETS   (N_SETS),
    .SET_BITS (SET_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle, then drive this cycle's inputs and let outputs settle.
  task automatic applyStimulus(input logic valid, input logic hit,
                               input logic [3:0] set, input logic [3:0] way,
                               input logic fillDone, input logic flushReq);
    @(posedge clk);
    #1;
    bus.acc_valid = valid;
    bus.acc_hit   = hit;
    bus.acc_set   = set;
    bus.acc_way   = way;
    bus.fill_done = fillDone;
    bus.flush_req = flushReq;
    #1;
  endtask

  task automatic doMiss(input string tag, input logic [3:0] set, input int delay,
                        input logic [3:0] expWay, input logic flushDuring);
    applyStimulus(1'b1, 1'b0, set, 4'd0, 1'b0, 1'b0);
    checkOutput({tag, "_acc_ready"}, bus.acc_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput({tag, "_select_fill_req"}, bus.fill_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, delay == 0, flushDuring);
    checkOutput({tag, "_fill_req"}, bus.fill_req, 1'b1);
    checkOutput({tag, "_fill_set"}, bus.fill_set, set);
    checkOutput({tag, "_fill_way"}, bus.fill_way, expWay);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, i == delay - 1, flushDuring);
      checkOutput({tag, "_fill_way_hold"}, bus.fill_way, expWay);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, flushDuring);
    checkOutput({tag, "_update_done"}, bus.done, 1'b0);
    checkOutput({tag, "_update_flush_busy"}, bus.flush_busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, flushDuring);
    checkOutput({tag, "_done"}, bus.done, 1'b1);
    checkOutput({tag, "_done_way"}, bus.done_way, expWay);
    checkOutput({tag, "_ready_after"}, bus.acc_ready, !flushDuring);
  endtask

  task automatic doHit(input string tag, input logic [3:0] set, input logic [3:0] way);
    applyStimulus(1'b1, 1'b1, set, way, 1'b0, 1'b0);
    checkOutput({tag, "_acc_ready"}, bus.acc_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput({tag, "_done"}, bus.done, 1'b1);
    checkOutput({tag, "_done_way"}, bus.done_way, way);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  busy;
    bit  ended;

    bus.acc_valid = 1'b0;
    bus.acc_hit   = 1'b0;
    bus.acc_set   = '0;
    bus.acc_way   = '0;
    bus.fill_done = 1'b0;
    bus.flush_req = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_acc_ready", bus.acc_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("rst_fill_req", bus.fill_req, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_done_way", bus.done_way, 4'd0);
    checkOutput("rst_flush_busy", bus.flush_busy, 1'b0);
    checkOutput("rst_fill_set", bus.fill_set, 4'd0);
    checkOutput("rst_fill_way", bus.fill_way, 4'd0);
    checkOutput("rst_acc_ready_low", bus.acc_ready, 1'b1);

    // Empty set fills way 0 then way 1.
    doMiss("miss3a", 4'd3, 2, 4'd0, 1'b0);
    doMiss("miss3b", 4'd3, 0, 4'd1, 1'b0);

    // Full set: victim is the oldest way.
    doMiss("miss5a", 4'd5, 0, 4'd0, 1'b0);
    doMiss("miss5b", 4'd5, 0, 4'd1, 1'b0);
    doHit("hit5", 4'd5, 4'd0);
    doMiss("miss5c", 4'd5, 1, 4'd1, 1'b0);
    checkOutput("set5_age_w0", dut.age_q[5][0], 32'd1);
    checkOutput("set5_age_w1", dut.age_q[5][1], 32'd0);

    // Tied ages resolve to way 0.
    doMiss("miss2a", 4'd2, 0, 4'd0, 1'b0);
    doMiss("miss2b", 4'd2, 0, 4'd1, 1'b0);
    ageTmp = dut.age_q;
    ageTmp[2][0] = 32'd7;
    ageTmp[2][1] = 32'd7;
    force dut.age_q = ageTmp;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    release dut.age_q;
    doMiss("miss2tie", 4'd2, 0, 4'd0, 1'b0);
    checkOutput("set2_age_w1", dut.age_q[2][1], 32'd8);

    // 300 back-to-back hits on way 0 of set 1.
    doMiss("miss1a", 4'd1, 0, 4'd0, 1'b0);
    doMiss("miss1b", 4'd1, 0, 4'd1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
      if (i == 1) begin
        checkOutput("stream_done", bus.done, 1'b1);
        checkOutput("stream_ready", bus.acc_ready, 1'b1);
      end
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("stream_last_done", bus.done, 1'b1);
    checkOutput("set1_age_w1_300", dut.age_q[1][1], 32'd300);
    checkOutput("set1_age_w0", dut.age_q[1][0], 32'd0);

    ageTmp = dut.age_q;
    ageTmp[1][1] = 32'hFFFF_FFFF;
    force dut.age_q = ageTmp;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    release dut.age_q;
    doHit("hitsat", 4'd1, 4'd0);
    checkOutput("set1_age_w1_sat", dut.age_q[1][1], 32'hFFFF_FFFF);

    // Flush requested during FILL waits for the miss to complete.
    doMiss("missflush", 4'd7, 1, 4'd0, 1'b1);
    busy  = 0;
    ended = 1'b0;
    for (int i = 0; i < 40 && !ended; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      if (bus.flush_busy) begin
        busy++;
        checkOutput("flush_ready_low", bus.acc_ready, 1'b0);
      end else begin
        ended = 1'b1;
        checkOutput("flush_ready_after", bus.acc_ready, 1'b1);
      end
    end
    checkOutput("flush_busy_cycles", busy, 32'd16);
    checkOutput("flush_ended", ended, 1'b1);
    for (int i = 0; i < 6; i++)
      doMiss("postflush", flushSets[i], 0, 4'd0, 1'b0);

    // Reset during FILL abandons the fill.
    applyStimulus(1'b1, 1'b0, 4'd9, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("rstfill_fill_req", bus.fill_req, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rstfill_fill_req_drop", bus.fill_req, 1'b0);
    checkOutput("rstfill_ready", bus.acc_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("rstfill_no_done1", bus.done, 1'b0);
    checkOutput("rstfill_no_update", bus.fill_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("rstfill_no_done2", bus.done, 1'b0);
    checkOutput("rstfill_ready_after", bus.acc_ready, 1'b1);
    doMiss("postrst5", 4'd5, 0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
